// File: rtl/motion_region_tracker.sv
// Run-length filtered motion accumulator: counts qualified motion pixels and
// their bounding box per frame, reporting the totals at each frame boundary.
module motion_region_tracker #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int RUN_LEN   = 3,
    parameter int MIN_COUNT = 64,
    parameter int CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             pixel_valid,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic             motion_flag,
    output logic             result_valid,
    output logic             motion_detected,
    output logic [CNT_W-1:0] motion_count,
    output logic [9:0]       x_min,
    output logic [9:0]       x_max,
    output logic [9:0]       y_min,
    output logic [9:0]       y_max
);

    localparam int               RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_COUNT);
    localparam logic [9:0]       X_OFF   = 10'(RUN_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             qualify;
    logic             in_range;
    logic [9:0]       x_lo;
    logic [CNT_W-1:0] acc_cnt;
    logic [9:0]       acc_xmin;
    logic [9:0]       acc_xmax;
    logic [9:0]       acc_ymin;
    logic [9:0]       acc_ymax;

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
        return (r >= RUN_MAX) ? RUN_MAX : r + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

    always_comb begin
        run_next = '0;
        if (x_pixel == 10'd0)
            run_next = RUN_W'(motion_flag);
        else if (motion_flag)
            run_next = run_inc(run);
        in_range = (32'(x_pixel) < H_RES) && (32'(y_pixel) < V_RES);
        qualify  = (run_next >= RUN_MAX) && in_range;
        // A qualifying run always spans RUN_LEN columns ending here, so no underflow.
        x_lo     = x_pixel - X_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            run             <= '0;
            acc_cnt         <= '0;
            acc_xmin        <= '1;
            acc_xmax        <= '0;
            acc_ymin        <= '1;
            acc_ymax        <= '0;
            result_valid    <= 1'b0;
            motion_detected <= 1'b0;
            motion_count    <= '0;
            x_min           <= '0;
            x_max           <= '0;
            y_min           <= '0;
            y_max           <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (frame_start) begin
                        state           <= REPORT;
                        result_valid    <= 1'b1;
                        motion_count    <= acc_cnt;
                        motion_detected <= (acc_cnt >= CNT_MIN);
                        if (acc_cnt == '0) begin
                            x_min <= '0;
                            x_max <= '0;
                            y_min <= '0;
                            y_max <= '0;
                        end else begin
                            x_min <= acc_xmin;
                            x_max <= acc_xmax;
                            y_min <= acc_ymin;
                            y_max <= acc_ymax;
                        end
                        run      <= '0;
                        acc_cnt  <= '0;
                        acc_xmin <= '1;
                        acc_xmax <= '0;
                        acc_ymin <= '1;
                        acc_ymax <= '0;
                    end else if (pixel_valid) begin
                        run <= run_next;
                        if (qualify) begin
                            acc_cnt <= cnt_inc(acc_cnt);
                            if (x_lo < acc_xmin)     acc_xmin <= x_lo;
                            if (x_pixel > acc_xmax)  acc_xmax <= x_pixel;
                            if (y_pixel < acc_ymin)  acc_ymin <= y_pixel;
                            if (y_pixel > acc_ymax)  acc_ymax <= y_pixel;
                        end
                    end
                end
                REPORT: state <= ACCUM;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_region_tracker.sv
// Bench for motion_region_tracker: table-driven frames, corner sequences and
// random frames compared against a sliding-window reference model.
module tb_motion_region_tracker;

    localparam int RUN_LEN   = 3;
    localparam int MIN_COUNT = 64;
    localparam int CNT_W     = 19;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             pixel_valid = 1'b0;
    logic [9:0]       x_pixel = '0;
    logic [9:0]       y_pixel = '0;
    logic             motion_flag = 1'b0;
    logic             result_valid;
    logic             motion_detected;
    logic [CNT_W-1:0] motion_count;
    logic [9:0]       x_min, x_max, y_min, y_max;

    motion_region_tracker #(
        .H_RES(640), .V_RES(480), .RUN_LEN(RUN_LEN),
        .MIN_COUNT(MIN_COUNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .motion_flag(motion_flag), .result_valid(result_valid),
        .motion_detected(motion_detected), .motion_count(motion_count),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: flags seen on the current line, and frame accumulators.
    int line_flags[$];
    int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;

    typedef struct {
        string name;
        int mode;            // 0 none, 1 rectangle, 2 runs of two
        int r0, r1, c0, c1;
        int fx0, fx1, fy0, fy1;
        int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax, e_det;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        line_flags.delete();
        m_cnt = 0; m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
    endtask

    task automatic pix(input int x, input int y, input int f);
        bit all_set;
        frame_start = 1'b0; pixel_valid = 1'b1;
        x_pixel = 10'(x); y_pixel = 10'(y); motion_flag = f[0];
        tick();
        if (x == 0) line_flags.delete();
        line_flags.push_back(f);
        if (line_flags.size() > RUN_LEN) void'(line_flags.pop_front());
        all_set = (line_flags.size() == RUN_LEN);
        foreach (line_flags[i]) if (line_flags[i] == 0) all_set = 1'b0;
        if (all_set) begin
            m_cnt++;
            if (x - (RUN_LEN - 1) < m_xmin) m_xmin = x - (RUN_LEN - 1);
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
        end
    endtask

    task automatic gap();
        frame_start = 1'b0; pixel_valid = 1'b0;
        x_pixel = 10'($urandom_range(0, 639)); motion_flag = 1'b1;
        tick();
    endtask

    // Frame boundary: junk flagged pixels ride along with frame_start and the
    // following cycle, and must not be accumulated.
    task automatic end_frame(input string name, input bit exp_rv, input int e_cnt,
                             input int e_xmin, input int e_xmax, input int e_ymin,
                             input int e_ymax, input int e_det);
        int held;
        frame_start = 1'b1; pixel_valid = 1'b1; motion_flag = 1'b1;
        x_pixel = 10'd7; y_pixel = 10'd7;
        tick();
        frame_start = 1'b0;
        check({name, ".result_valid"}, int'(result_valid), int'(exp_rv));
        if (exp_rv) begin
            check({name, ".count"}, int'(motion_count), e_cnt);
            check({name, ".x_min"}, int'(x_min), e_xmin);
            check({name, ".x_max"}, int'(x_max), e_xmax);
            check({name, ".y_min"}, int'(y_min), e_ymin);
            check({name, ".y_max"}, int'(y_max), e_ymax);
            check({name, ".detected"}, int'(motion_detected), e_det);
        end
        held = int'(motion_count);
        x_pixel = 10'd8;
        tick();
        check({name, ".pulse_end"}, int'(result_valid), 0);
        check({name, ".count_hold"}, int'(motion_count), held);
        pixel_valid = 1'b0;
        model_clear();
    endtask

    task automatic end_frame_model(input string name);
        if (m_cnt == 0)
            end_frame(name, 1'b1, 0, 0, 0, 0, 0, 0);
        else
            end_frame(name, 1'b1, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax,
                      int'(m_cnt >= MIN_COUNT));
    endtask

    function automatic int flag_of(input vec_t v, input int x, input int y);
        case (v.mode)
            1: return int'(x >= v.fx0 && x <= v.fx1 && y >= v.fy0 && y <= v.fy1);
            2: return int'((x % 4) < 2);
            default: return 0;
        endcase
    endfunction

    initial begin
        model_clear();
        vecs.push_back('{"zero_frame", 0, 0, 3, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{"line_run10", 1, 100, 100, 190, 220, 200, 209, 100, 100,
                         8, 200, 209, 100, 100, 0});
        vecs.push_back('{"runs_of_two", 2, 0, 3, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{"block10x10", 1, 20, 29, 40, 69, 50, 59, 20, 29,
                         80, 50, 59, 20, 29, 1});
        vecs.push_back('{"count_64", 1, 3, 3, 0, 65, 0, 65, 3, 3, 64, 0, 65, 3, 3, 1});
        vecs.push_back('{"count_63", 1, 3, 3, 0, 64, 0, 64, 3, 3, 63, 0, 64, 3, 3, 0});

        // Reset state
        repeat (3) tick();
        check("rst.result_valid", int'(result_valid), 0);
        check("rst.detected", int'(motion_detected), 0);
        check("rst.count", int'(motion_count), 0);
        check("rst.x_min", int'(x_min), 0);
        check("rst.x_max", int'(x_max), 0);
        check("rst.y_min", int'(y_min), 0);
        check("rst.y_max", int'(y_max), 0);
        rst_n = 1'b1;
        tick();

        // First frame_start leaves IDLE without reporting
        end_frame("first_fs", 1'b0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            for (int y = vecs[k].r0; y <= vecs[k].r1; y++)
                for (int x = vecs[k].c0; x <= vecs[k].c1; x++)
                    pix(x, y, flag_of(vecs[k], x, y));
            end_frame(vecs[k].name, 1'b1, vecs[k].e_cnt, vecs[k].e_xmin, vecs[k].e_xmax,
                      vecs[k].e_ymin, vecs[k].e_ymax, vecs[k].e_det);
        end

        // Run must restart at x=0 rather than continue from the previous line end
        pix(638, 5, 1); pix(639, 5, 1); pix(0, 6, 1); pix(1, 6, 0);
        end_frame("line_wrap", 1'b1, 0, 0, 0, 0, 0, 0);

        // Shortest qualifying run starting at column 0
        pix(0, 6, 1); pix(1, 6, 1); pix(2, 6, 1);
        end_frame("run_at_x0", 1'b1, 1, 0, 2, 6, 6, 0);

        // Invalid cycles hold the run
        pix(10, 7, 1); gap(); pix(11, 7, 1); gap(); gap(); pix(12, 7, 1);
        end_frame("valid_gaps", 1'b1, 1, 10, 12, 7, 7, 0);

        // Random frames against the model
        for (int f = 0; f < 8; f++) begin
            int r0, nr, c0, w;
            r0 = $urandom_range(0, 470);
            nr = $urandom_range(1, 4);
            c0 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 600);
            w  = $urandom_range(8, 39);
            for (int y = r0; y < r0 + nr; y++)
                for (int x = c0; x < c0 + w; x++) begin
                    if ($urandom_range(0, 7) == 0) gap();
                    pix(x, y, int'($urandom_range(0, 3) != 0));
                end
            end_frame_model($sformatf("rand%0d", f));
        end

        // Reset mid-frame while a flagged block is streaming
        for (int y = 20; y <= 22; y++)
            for (int x = 40; x <= 69; x++) pix(x, y, int'(x >= 50 && x <= 59));
        #2 rst_n = 1'b0;
        #1;
        check("midrst.count", int'(motion_count), 0);
        check("midrst.result_valid", int'(result_valid), 0);
        tick(); tick();
        rst_n = 1'b1;
        model_clear();
        for (int x = 40; x <= 69; x++) pix(x, 23, int'(x >= 50 && x <= 59));
        end_frame("midrst.fs1", 1'b0, 0, 0, 0, 0, 0, 0);
        for (int y = 30; y <= 31; y++)
            for (int x = 40; x <= 69; x++) pix(x, y, int'(x >= 50 && x <= 59));
        end_frame("midrst.fs2", 1'b1, 16, 50, 59, 30, 31, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
